// File: rtl/nibble_serial_addsub_pkg.sv
// Shared constants, FSM state type and saturation helper for the nibble-serial add/sub.
// The NIBBLE_SERIAL_ADDSUB_SAT_EN build uses sat_value to clamp overflowed results.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;
    localparam int MAX_W    = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Most positive (sign=0) or most negative (sign=1) two's-complement value of 'width' bits.
    function automatic logic [MAX_W-1:0] sat_value(input logic sign, input int width);
        logic [MAX_W-1:0] msb_only;
        msb_only = MAX_W'(1) << (width - 1);
        if (sign) begin
            return msb_only;
        end
        return msb_only - MAX_W'(1);
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Start/done handshake and operand/result bus between a datapath and the serial add/sub.
interface nibble_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/four_bit_rca.sv
// Four-bit ripple-carry adder: the single arithmetic element reused on every nibble.
module four_bit_rca
    import nibble_serial_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                Cin,
    output logic [NIBBLE_W-1:0] S,
    output logic                Cout
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = Cin;

    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
        assign S[gi]       = A[gi] ^ B[gi] ^ carry[gi];
        assign carry[gi+1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
    end

    assign Cout = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract computed one nibble per clock through one four_bit_rca.
// Define NIBBLE_SERIAL_ADDSUB_SAT_EN to saturate the result on signed overflow.
module nibble_serial_addsub
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nibble_serial_addsub_if.slave  bus
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] a_reg,      a_next;
    logic [WIDTH-1:0] b_reg,      b_next;
    logic             carry_reg,  carry_next;
    logic [IDX_W-1:0] idx_reg,    idx_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             cout_reg,   cout_next;
    logic             ovf_reg,    ovf_next;

    logic [NIBBLE_W-1:0] a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] b_nib [NIBBLES];
    logic [NIBBLE_W-1:0] sum_nib;
    logic                sum_cout;
    logic                ovf_now;

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
        assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
    end

    four_bit_rca u_rca (
        .A    (a_nib[idx_reg]),
        .B    (b_nib[idx_reg]),
        .Cin  (carry_reg),
        .S    (sum_nib),
        .Cout (sum_cout)
    );

    // Same-sign operands producing an opposite-sign top nibble means overflow.
    assign ovf_now = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum_nib[NIBBLE_W-1] != a_reg[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            carry_reg  <= 1'b0;
            idx_reg    <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            carry_reg  <= carry_next;
            idx_reg    <= idx_next;
            result_reg <= result_next;
            cout_reg   <= cout_next;
            ovf_reg    <= ovf_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        carry_next  = carry_reg;
        idx_next    = idx_reg;
        result_next = result_reg;
        cout_next   = cout_reg;
        ovf_next    = ovf_reg;

        case (state_reg)
            RUN: begin
                result_next[idx_reg*NIBBLE_W +: NIBBLE_W] = sum_nib;
                carry_next = sum_cout;
                idx_next   = idx_reg + IDX_W'(1);
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                    cout_next  = sum_cout;
                    ovf_next   = ovf_now;
`ifdef NIBBLE_SERIAL_ADDSUB_SAT_EN
                    if (ovf_now) begin
                        result_next = WIDTH'(sat_value(a_reg[WIDTH-1], WIDTH));
                    end
`endif
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; subtract is A + ~B + 1.
                if (bus.start) begin
                    a_next     = bus.a;
                    b_next     = bus.op_sub ? ~bus.b : bus.b;
                    carry_next = bus.op_sub;
                    idx_next   = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    assign bus.busy   = (state_reg == RUN);
    assign bus.done   = (state_reg == DONE);
    assign bus.result = result_reg;
    assign bus.cout   = cout_reg;
    assign bus.ovf    = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub (WIDTH=16): directed table, random ops
// against an arithmetic reference model, and handshake/reset corner sequences.
module tb_nibble_serial_addsub;

    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    nibble_serial_addsub_if #(.WIDTH(W)) bus ();

    nibble_serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  exp_result;
        logic          exp_cout;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic logic [W+1:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int           sa;
        int           sb;
        int           sr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (op) begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sb;
        end else begin
            r  = a + b;
            c  = ((int'(a) + int'(b)) > 65535);
            sr = sa + sb;
        end
        v = (sr > 32767) || (sr < -32768);
`ifdef NIBBLE_SERIAL_ADDSUB_SAT_EN
        if (v) r = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return {v, c, r};
    endfunction

    // Present a request for exactly one clock; returns at the negedge after acceptance.
    task automatic start_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start  = 1'b1;
        bus.op_sub = op;
        bus.a      = a;
        bus.b      = b;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles, output bit ok);
        busy_cycles = 0;
        ok          = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
    endtask

    task automatic run_and_check(input string tag, input logic op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] er,
                                 input logic ec, input logic ev, input bit check_lat);
        int bc;
        bit ok;
        start_op(op, a, b);
        wait_done(bc, ok);
        if (ok) begin
            if (check_lat) check({tag, "_busy_cycles"}, bc, 4);
            check({tag, "_result"}, bus.result, er);
            check({tag, "_cout"}, bus.cout, ec);
            check({tag, "_ovf"}, bus.ovf, ev);
            $display("op=%0d a=%04h b=%04h -> result=%04h cout=%0d ovf=%0d", op, a, b,
                     bus.result, bus.cout, bus.ovf);
            @(negedge clk);
            check({tag, "_done_pulse"}, bus.done, 0);
        end
    endtask

    initial begin
        logic [W+1:0] m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rop;
        int           bc;
        bit           ok;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
`ifdef NIBBLE_SERIAL_ADDSUB_SAT_EN
        vecs[2] = '{1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
`else
        vecs[2] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
`endif
        vecs[4] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].exp_result, vecs[i].exp_cout, vecs[i].exp_ovf, 1'b1);
        end

        for (int i = 0; i < 40; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rop = 1'($urandom_range(0, 1));
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) ra = 16'h8000 | ra;
            m = model(rop, ra, rb);
            run_and_check($sformatf("rnd%0d", i), rop, ra, rb, m[W-1:0], m[W], m[W+1], 1'b0);
        end

        // A start pulse mid-RUN must be ignored.
        m = model(1'b0, 16'h1111, 16'h2222);
        start_op(1'b0, 16'h1111, 16'h2222);
        @(negedge clk);
        bus.start = 1'b1; bus.op_sub = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h0F0F;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(bc, ok);
        if (ok) begin
            check("midrun_result", bus.result, m[W-1:0]);
            check("midrun_cout", bus.cout, m[W]);
            $display("midrun ignored: result=%04h", bus.result);
            @(negedge clk);
            check("midrun_no_rerun", bus.busy, 0);
        end

        // Start held in the DONE cycle: back-to-back with no IDLE gap.
        start_op(1'b0, 16'h0F0F, 16'h00F1);
        wait_done(bc, ok);
        if (ok) begin
            m = model(1'b0, 16'h0F0F, 16'h00F1);
            check("b2b_first_result", bus.result, m[W-1:0]);
            bus.start = 1'b1; bus.op_sub = 1'b1; bus.a = 16'h7000; bus.b = 16'h9000;
            @(negedge clk);
            bus.start = 1'b0;
            check("b2b_no_gap_busy", bus.busy, 1);
            wait_done(bc, ok);
            if (ok) begin
                m = model(1'b1, 16'h7000, 16'h9000);
                check("b2b_second_busy_cycles", bc, 4);
                check("b2b_second_result", bus.result, m[W-1:0]);
                check("b2b_second_ovf", bus.ovf, m[W+1]);
                $display("b2b second: result=%04h ovf=%0d", bus.result, bus.ovf);
            end
            @(negedge clk);
        end

        // Async reset in RUN cycle 2 clears outputs without a clock edge.
        start_op(1'b0, 16'h5555, 16'h2222);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_result", bus.result, 0);
        check("arst_cout", bus.cout, 0);
        check("arst_ovf", bus.ovf, 0);
        $display("async reset mid-run: busy=%0d result=%04h", bus.busy, bus.result);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_and_check("post_rst", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Sequencer that performs WIDTH-bit add/subtract one nibble per cycle through a single four_bit_rca instance (ports A, B, Cin, S, Cout).
- Holds the inter-nibble carry in a flop and collects the result.
- Presents a start/done handshake to the surrounding datapath.
- Trades latency for area against a full-width adder.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8.
- NIBBLES, WIDTH/4, derived local constant: number of RUN cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- op_sub  input  1  0 = A+B, 1 = A−B; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result, cout and ovf are valid from this cycle.
- result  output  WIDTH  sum/difference.
- cout  output  1  final carry; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (async, rst_n=0), effective immediately including mid-operation:
  - state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0.
  - Internal operand and carry registers cleared.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - start is accepted in IDLE or DONE, on the edge where start=1.
  - On acceptance: latch a; latch b, or ~b if op_sub=1; carry flop ← op_sub; nibble index ← 0; state → RUN.
  - start while in RUN is ignored and has no side effects.
- RUN cycle k (k = 0..NIBBLES−1):
  - Adder inputs: A=a_q[4k+3:4k], B=b_eff_q[4k+3:4k], Cin=carry_q.
  - On the edge: result[4k+3:4k] ← S; carry_q ← Cout; index ← k+1.
- After the last nibble (index NIBBLES−1):
  - state → DONE; cout ← Cout.
  - ovf ← (a_q[MSB] == b_eff_q[MSB]) && (S[3] != a_q[MSB]).
- Latency: done is high in the cycle following the NIBBLES-th clock edge after the accepting edge. For WIDTH=16, done is high in the cycle after the 4th edge following the accepting edge.
- DONE lasts exactly one cycle:
  - done=1 during DONE.
  - Next state is IDLE, or RUN if start=1 (back-to-back; done still pulses for the prior operation).
- Output hold: result, cout and ovf hold their values until the next accepted start. They are not cleared on the DONE→IDLE transition.
- Result nibbles above index k are undefined during RUN; only values at done are guaranteed.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - No sign extension.
  - The carry chain never leaks between operations because the carry flop is reloaded on every start.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDSUB_SAT_EN.
- Defined: when ovf=1 at completion, result saturates.
  - a_q[MSB]=0 → 2^(WIDTH−1)−1.
  - a_q[MSB]=1 → 2^(WIDTH−1).
  - ovf and cout report the unsaturated values.
- Undefined: result is the raw wrapped value.
- No port difference between the two builds.

Decomposition:
- Package nibble_serial_pkg holds:
  - NIBBLE_W = 4.
  - State enum {IDLE, RUN, DONE}.
  - Helper function sat_value(sign, width).
- Sub-module: four_bit_rca, instantiated exactly once. No other sub-modules.
- Index counter width is $clog2(NIBBLES).

Test Plan (WIDTH=16):
- Basic add: add 0x1234 + 0x0FFF, start for one cycle → busy for 4 cycles, done pulse, result=0x2233, cout=0, ovf=0.
- Unsigned wrap: add 0xFFFF + 0x0001 → result=0x0000, cout=1, ovf=0.
- Signed-overflow subtract: sub 0x8000 − 0x0001 → result=0x7FFF, cout=1, ovf=1; with SAT_EN → result=0x8000, ovf=1.
- Signed-overflow add: add 0x7FFF + 0x0001 → result=0x8000, ovf=1; with SAT_EN → 0x7FFF.
- Handshake corners:
  - Pulse start again mid-RUN with different operands → ignored; first result is unchanged.
  - Start held high in the DONE cycle → done pulses and the second operation runs with no IDLE gap.
- Reset mid-operation: drive rst_n low in RUN cycle 2 → busy, done, result, cout and ovf go to 0 without waiting for clk. After release, 0x0001 + 0x0001 → 0x0002.
